// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//
// Power-up and lock supervisor for the clock-generation PLL. Runs on the board
// reference clock, pulses the PLL areset, waits for a stable lock and only then
// releases the system reset. A lock loss in RUN re-sequences the PLL; repeated
// lock timeouts end in the terminal FAILED state (left only through areset).
//
// Parameters:
//   PLL_RST_CYCLES  cycles pll_areset is held high per PLL reset pulse (>= 1)
//   LOCK_TIMEOUT    cycles to wait for lock after each reset pulse (>= 2)
//   STABLE_CYCLES   consecutive locked cycles required before release (>= 1)
//   MAX_RETRIES     PLL reset retries after the first timeout (0..15)
//
// Ports:
//   inclk0         in   reference clock (PLL input clock)
//   areset         in   asynchronous active-high reset
//   pll_locked     in   PLL locked flag, asynchronous to inclk0
//   pll_areset     out  PLL areset drive, active-high
//   sys_rst        out  system reset for PLL-clocked logic, active-high
//   ready          out  high only in RUN
//   fail           out  high only in FAILED
//   retry_cnt      out  lock-timeout retries used in the current sequence
//   lock_loss_cnt  out  RUN-state lock losses since areset, saturating at 255
//   state          out  RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAILED=4
//
// Build option:
//   PLL_LOCK_GLITCH_FILTER_EN  when defined, a RUN-state lock loss needs the
//                              synchronised lock low for 4 consecutive cycles.
//
// Every output is a flop; outputs are updated on the same edge as the state
// change that implies them.

`timescale 1ns / 1ps

module pll_lock_sequencer #(
    parameter int unsigned PLL_RST_CYCLES = 10,
    parameter int unsigned LOCK_TIMEOUT   = 50000,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic       inclk0,
    input  logic       areset,
    input  logic       pll_locked,
    output logic       pll_areset,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt,
    output logic [2:0] state
);

    // Counter widths; a 1-cycle parameter still needs a 1-bit counter.
    localparam int unsigned RstW = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
    localparam int unsigned ToW  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int unsigned StW  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    localparam logic [RstW-1:0] RstLast  = RstW'(PLL_RST_CYCLES - 1);
    localparam logic [ToW-1:0]  ToLast   = ToW'(LOCK_TIMEOUT - 1);
    localparam logic [StW-1:0]  StLast   = StW'(STABLE_CYCLES - 1);
    localparam logic [3:0]      RetryMax = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StResetPll = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRun      = 3'd3,
        StFailed   = 3'd4
    } state_e;

    state_e          state_q;
    logic [RstW-1:0] rst_cnt_q;
    logic [ToW-1:0]  to_cnt_q;
    logic [StW-1:0]  st_cnt_q;

    // ------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous PLL lock flag.
    // ------------------------------------------------------------------
    logic lk_m;
    logic lk_s;

    always_ff @(posedge inclk0 or posedge areset) begin
        if (areset) begin
            lk_m <= 1'b0;
            lk_s <= 1'b0;
        end else begin
            lk_m <= pll_locked;
            lk_s <= lk_m;
        end
    end

    // ------------------------------------------------------------------
    // Lock-loss qualification while in RUN.
    // ------------------------------------------------------------------
    logic loss_event;

`ifdef PLL_LOCK_GLITCH_FILTER_EN
    // Counts consecutive low cycles of lk_s in RUN; any high cycle or any
    // other state clears it, so a new RUN always starts with a clean filter.
    logic [1:0] flt_cnt_q;

    assign loss_event = !lk_s && (flt_cnt_q == 2'd3);

    always_ff @(posedge inclk0 or posedge areset) begin
        if (areset) begin
            flt_cnt_q <= 2'd0;
        end else if ((state_q != StRun) || lk_s) begin
            flt_cnt_q <= 2'd0;
        end else if (!loss_event) begin
            flt_cnt_q <= flt_cnt_q + 2'd1;
        end
    end
`else
    assign loss_event = !lk_s;
`endif

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge inclk0 or posedge areset) begin
        if (areset) begin
            state_q       <= StResetPll;
            rst_cnt_q     <= '0;
            to_cnt_q      <= '0;
            st_cnt_q      <= '0;
            pll_areset    <= 1'b1;
            sys_rst       <= 1'b1;
            ready         <= 1'b0;
            fail          <= 1'b0;
            retry_cnt     <= 4'd0;
            lock_loss_cnt <= 8'd0;
        end else begin
            case (state_q)
                StResetPll: begin
                    if (rst_cnt_q == RstLast) begin
                        state_q    <= StWaitLock;
                        to_cnt_q   <= '0;
                        pll_areset <= 1'b0;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end

                StWaitLock: begin
                    // Lock is tested first so it wins on the timeout cycle.
                    if (lk_s) begin
                        state_q  <= StStable;
                        st_cnt_q <= '0;
                    end else if (to_cnt_q == ToLast) begin
                        if (retry_cnt == RetryMax) begin
                            state_q <= StFailed;
                            fail    <= 1'b1;
                        end else begin
                            retry_cnt  <= retry_cnt + 4'd1;
                            state_q    <= StResetPll;
                            rst_cnt_q  <= '0;
                            pll_areset <= 1'b1;
                        end
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end

                StStable: begin
                    // Unfiltered: any low cycle restarts the lock wait, but the
                    // retry budget of this sequence is kept.
                    if (!lk_s) begin
                        state_q  <= StWaitLock;
                        to_cnt_q <= '0;
                    end else if (st_cnt_q == StLast) begin
                        state_q   <= StRun;
                        retry_cnt <= 4'd0;
                        sys_rst   <= 1'b0;
                        ready     <= 1'b1;
                    end else begin
                        st_cnt_q <= st_cnt_q + 1'b1;
                    end
                end

                StRun: begin
                    if (loss_event) begin
                        state_q    <= StResetPll;
                        rst_cnt_q  <= '0;
                        pll_areset <= 1'b1;
                        sys_rst    <= 1'b1;
                        ready      <= 1'b0;
                        if (lock_loss_cnt != 8'hff) begin
                            lock_loss_cnt <= lock_loss_cnt + 8'd1;
                        end
                    end
                end

                StFailed: begin
                    // Terminal; only areset leaves this state.
                end

                default: begin
                    // Unreachable encodings fall back to a fresh PLL reset.
                    state_q    <= StResetPll;
                    rst_cnt_q  <= '0;
                    pll_areset <= 1'b1;
                    sys_rst    <= 1'b1;
                    ready      <= 1'b0;
                    fail       <= 1'b0;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Power-up and lock supervisor for the clock-generation PLL. It runs on the 50 MHz board reference clock, drives the PLL's `areset` input, and consumes the PLL's `locked` output. It releases the system reset only after lock has been stable for a programmable interval. On loss of lock it re-sequences, and after repeated lock timeouts it declares failure.

## Interface
- `PLL_RST_CYCLES`, 10: cycles `pll_areset` is held high per PLL reset pulse (≥1).
- `LOCK_TIMEOUT`, 50000: cycles to wait for lock after the reset pulse (1 ms at 50 MHz).
- `STABLE_CYCLES`, 1024: consecutive locked cycles required before release (≥1).
- `MAX_RETRIES`, 3: PLL reset retries after the first timeout before failing (0–15).

Ports:
- `inclk0`  in  1  reference clock; the PLL input clock, not a PLL output.
- `areset`  in  1  asynchronous, active-high reset.
- `pll_locked`  in  1  PLL `locked` output; asynchronous to `inclk0`.
- `pll_areset`  out  1  drives the PLL `areset` input, active-high.
- `sys_rst`  out  1  system reset for logic clocked by `c0`/`c1`/`c2`, active-high.
- `ready`  out  1  high only in RUN.
- `fail`  out  1  high only in FAILED.
- `retry_cnt`  out  4  lock-timeout retries used in the current sequence.
- `lock_loss_cnt`  out  8  RUN-state lock losses since `areset`; saturates at 255.
- `state`  out  3  encoded FSM state: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAILED=4.

## Operation
- **Synchronizer.** `pll_locked` passes through a 2-flop synchronizer clocked by `inclk0` to produce `lk_s`. Only `lk_s` is used internally.
- **Reset values** (while `areset`=1 and immediately after release):
  - state RESET_PLL, `pll_areset`=1, `sys_rst`=1
  - `ready`=0, `fail`=0
  - `retry_cnt`=0, `lock_loss_cnt`=0, synchronizer flops=0
- All outputs are registered and decoded from the current state and counters.
- **RESET_PLL.** `pll_areset`=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK. The cycle counter clears on entry.
- **WAIT_LOCK.** `pll_areset`=0 and the timeout counter increments every cycle.
  - `lk_s`=1: go to STABLE.
  - Otherwise, when the counter reaches LOCK_TIMEOUT−1:
    - if `retry_cnt`==MAX_RETRIES, go to FAILED;
    - else increment `retry_cnt` and go to RESET_PLL.
  - If `lk_s` rises on the timeout cycle, lock wins.
- **STABLE.** A counter counts consecutive `lk_s`=1 cycles.
  - Any `lk_s`=0: return to WAIT_LOCK with the timeout counter cleared; `retry_cnt` is unchanged.
  - Counter reaches STABLE_CYCLES−1: go to RUN and clear `retry_cnt`.
- **RUN.** `sys_rst`=0, `ready`=1. A lock-loss event increments `lock_loss_cnt` (saturating) and goes to RESET_PLL. The `sys_rst` reassertion is registered on the same edge as the state change.
- **FAILED.** `pll_areset`=0, `sys_rst`=1, `fail`=1. This state is terminal; only `areset` exits it.
- **Counter widths.** Each counter is sized with `$clog2` of its parameter and compares for equality only, with no wrap. `LOCK_TIMEOUT` ≥ 2.

## Timing
- `pll_locked` rising to `lk_s`=1: 2 `inclk0` edges.
- WAIT_LOCK to RUN: minimum STABLE_CYCLES+1 cycles after `lk_s` rises.
- Entering RUN:
  - `sys_rst` falls and `ready` rises on the same edge that state becomes 3.
  - With the default configuration, `sys_rst` falls ≥ 3+STABLE_CYCLES cycles after `pll_locked` rises.
- Lock loss in RUN to `sys_rst`=1:
  - 3 cycles after `pll_locked` falls without the filter;
  - 6 cycles with the filter.
- `areset` asserted mid-sequence forces all reset values asynchronously. After deassertion the sequence restarts at RESET_PLL on the next edge, and `lock_loss_cnt` clears.
- No output glitches: every output comes straight from a flop.

## Configuration
- `PLL_LOCK_GLITCH_FILTER_EN` defined:
  - in RUN, a lock-loss event requires `lk_s`=0 for 4 consecutive cycles; a shorter low pulse is ignored and the filter count resets on `lk_s`=1;
  - STABLE remains unfiltered.
- Undefined: a single `lk_s`=0 cycle in RUN is a lock-loss event.

## Test plan
Benches use `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT`=100, `STABLE_CYCLES`=16, `MAX_RETRIES`=2, and a 20 ns clock.
- **Clean bring-up.** Release `areset`; assert `pll_locked` 10 cycles after `pll_areset` falls.
  - Required: `pll_areset` high exactly 4 cycles;
  - `sys_rst` falls and `ready`=1 exactly 2+16+1 cycles after `pll_locked` rises;
  - `retry_cnt`=0.
- **Timeout to FAILED.** Hold `pll_locked`=0.
  - Required: 3 `pll_areset` pulses, `retry_cnt` reaching 2, then `state`=4 and `fail`=1.
  - Only `areset` recovers.
- **Unstable lock.** In STABLE, drop `pll_locked` for 1 cycle at count 10.
  - Required: `state` returns to 1; a further 16 stable cycles are needed before RUN.
- **Loss in RUN.** Drop `pll_locked` for 8 cycles.
  - Required: `sys_rst`=1, `lock_loss_cnt`=1, then a new `pll_areset` pulse and re-lock to RUN.
  - Repeat 300 times: `lock_loss_cnt` holds at 255.
- **Glitch filter.** In RUN, apply a 2-cycle low pulse on `pll_locked`.
  - With `PLL_LOCK_GLITCH_FILTER_EN`: no reset and count 0.
  - Without: `sys_rst`=1 and count 1.
- **Mid-sequence reset.** Assert `areset` during STABLE at count 8.
  - Required: immediate reset values on all outputs;
  - clean restart from RESET_PLL after release.
